// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, state type and branch-offset helper for the MIPS fetch stage
package mips_pkg;

    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [5:0]  OP_RTYPE   = 6'b000000;
    localparam logic [5:0]  OP_BEQ     = 6'b000100;
    localparam int          PC_INC     = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // Signed word offset of a branch turned into a 32-bit byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - 2-entry synchronous FIFO with synchronous clear
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clear               drop all entries (wins over push/pop)
//   push, push_data     write one entry (ignored when full and not popping)
//   pop                 remove the head (ignored when empty)
//   head                oldest entry
//   count, full, empty  occupancy
module fetch_buf
    import mips_pkg::*;
#(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] ent0;
    logic [W-1:0] ent1;
    logic [1:0]   cnt;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    // ent0 is always the head; a pop shifts ent1 down.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else if (clear) begin
            cnt <= 2'd0;
        end else if (do_pop && do_push) begin
            if (cnt == 2'd1) begin
                ent0 <= push_data;
            end else begin
                ent0 <= ent1;
                ent1 <= push_data;
            end
        end else if (do_pop) begin
            ent0 <= ent1;
            cnt  <= cnt - 2'd1;
        end else if (do_push) begin
            if (cnt == 2'd0) begin
                ent0 <= push_data;
            end else begin
                ent1 <= push_data;
            end
            cnt <= cnt + 2'd1;
        end
    end

    assign head  = ent0;
    assign count = cnt;
    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);

endmodule

// File: rtl/instrfetch.sv
// rtl/instrfetch.sv - instruction fetch stage: PC, writable imem, 2-entry output buffer, branch redirect
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   imem_we, imem_wa, imem_wd        instruction memory write port
//   redirect, redirect_pc,           taken branch: pc <= redirect_pc + 4 + (imm << 2)
//   redirect_imm
//   out_valid, out_ready             handshake towards decode
//   out_instr, out_pc, out_opcode    buffer head
//   halted                           fetch stopped by HALT_INSTR
module instrfetch #(
    parameter int          PC_W       = 8,
    parameter logic [31:0] HALT_INSTR = mips_pkg::HALT_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_we,
    input  logic [PC_W-3:0] imem_wa,
    input  logic [31:0]     imem_wd,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic [15:0]     redirect_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [5:0]      out_opcode,
    output logic            halted
);
    import mips_pkg::*;

    localparam int DEPTH = 1 << (PC_W - 2);
    localparam int BW    = 32 + PC_W;

    logic [31:0]     imem [DEPTH];
    logic [PC_W-3:0] pc_word;      // pc is always word aligned; only the word index is kept
    fetch_state_e    state;
    fetch_state_e    state_next;
    logic            fetch_en;
    logic [31:0]     fetch_word;
    logic [31:0]     target_full;

    logic [BW-1:0]   buf_head;
    logic [1:0]      buf_count;
    logic            buf_full;
    logic            buf_empty;
    logic            unused_bits;

    assign fetch_word = imem[pc_word];

    // Low two bits of redirect_pc are dropped before the add; the sum is
    // then word aligned, so truncating to the word index gives the target.
    assign target_full = 32'({redirect_pc[PC_W-1:2], 2'b00}) + 32'(PC_INC)
                       + branch_offset(redirect_imm);
    assign unused_bits = &{1'b0, redirect_pc[1:0], target_full[31:PC_W], target_full[1:0]};

    always_comb begin
        state_next = state;
        fetch_en   = 1'b0;
        if (redirect) begin
            state_next = RUN;
        end else if (state == RUN && !buf_full) begin
            fetch_en = 1'b1;
            if (fetch_word == HALT_INSTR) begin
                state_next = HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            pc_word <= '0;
        end else begin
            state <= state_next;
            if (redirect) begin
                pc_word <= target_full[PC_W-1:2];
            end else if (fetch_en) begin
                pc_word <= pc_word + 1'b1;
            end
        end
    end

    // Write lands at the edge, so a same-cycle fetch of that word sees the old value.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_wa] <= imem_wd;
        end
    end

    fetch_buf #(
        .W (BW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (fetch_en),
        .push_data ({fetch_word, pc_word, 2'b00}),
        .pop       (out_ready && !buf_empty),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign out_valid  = (buf_count != 2'd0);
    assign out_instr  = out_valid ? buf_head[BW-1:PC_W] : 32'd0;
    assign out_pc     = out_valid ? buf_head[PC_W-1:0] : '0;
    assign out_opcode = out_instr[31:26];
    assign halted     = (state == HALT);

endmodule

// File: tb/tb_instrfetch.sv
// tb/tb_instrfetch.sv - self-checking bench for instrfetch
module tb_instrfetch;

    localparam int PC_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_we = 1'b0;
    logic [5:0]  imem_wa = '0;
    logic [31:0] imem_wd = '0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic [15:0] redirect_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic [5:0]  out_opcode;
    logic        halted;

    instrfetch #(.PC_W(PC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_we      (imem_we),
        .imem_wa      (imem_wa),
        .imem_wd      (imem_wd),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .redirect_imm (redirect_imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_opcode   (out_opcode),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic        redir;
        logic [7:0]  rpc;
        logic [15:0] imm;
        logic        ready;
        logic        e_valid;
        logic [7:0]  e_pc;
        logic [31:0] e_instr;
        logic        e_halted;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        int          pc;
    } ent_t;

    vec_t        tbl[$];
    ent_t        mq[$];
    logic [31:0] mmem [64];
    int          m_pc;
    logic        m_halted;
    int          checks = 0;
    int          failures = 0;

    localparam logic [31:0] S0   = 32'h0043_0822;
    localparam logic [31:0] S2   = 32'h1022_0003;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    function automatic logic [31:0] pat(input int i);
        return {6'h23, 10'h0, 16'(i)};
    endfunction

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, step, act, exp);
        end
    endtask

    // Reference: buffer as a queue, pc as a byte address, applied per cycle.
    task automatic model_update(input vec_t v);
        int n;
        int simm;
        if (v.rst) begin
            mq.delete();
            m_pc = 0;
            m_halted = 1'b0;
        end else if (v.redir) begin
            mq.delete();
            simm = int'($signed(v.imm));
            m_pc = ((int'(v.rpc) & ~3) + 4 + simm * 4) & 'hFC;
            m_halted = 1'b0;
        end else begin
            n = mq.size();
            if (n > 0 && v.ready) void'(mq.pop_front());
            if (!m_halted && n < 2) begin
                mq.push_back('{w: mmem[m_pc / 4], pc: m_pc});
                if (mmem[m_pc / 4] == HALT) m_halted = 1'b1;
                m_pc = (m_pc + 4) % 256;
            end
        end
        if (v.we) mmem[v.wa] = v.wd;
    endtask

    task automatic step(input vec_t v, input int idx);
        rst          = v.rst;
        imem_we      = v.we;
        imem_wa      = v.wa;
        imem_wd      = v.wd;
        redirect     = v.redir;
        redirect_pc  = v.rpc;
        redirect_imm = v.imm;
        out_ready    = v.ready;
        model_update(v);
        @(posedge clk);
        #1;
        chk("model_valid", idx, 32'(out_valid), 32'(mq.size() > 0));
        chk("model_halted", idx, 32'(halted), 32'(m_halted));
        if (mq.size() > 0) begin
            chk("model_pc", idx, 32'(out_pc), 32'(mq[0].pc));
            chk("model_instr", idx, out_instr, mq[0].w);
            chk("model_opcode", idx, 32'(out_opcode), 32'(mq[0].w[31:26]));
        end
    endtask

    task automatic add(input logic r, input logic we, input logic [5:0] wa, input logic [31:0] wd,
                       input logic rd, input logic [7:0] rpc, input logic [15:0] imm, input logic rdy,
                       input logic ev, input logic [7:0] epc, input logic [31:0] ei, input logic eh);
        tbl.push_back('{rst: r, we: we, wa: wa, wd: wd, redir: rd, rpc: rpc, imm: imm, ready: rdy,
                        e_valid: ev, e_pc: epc, e_instr: ei, e_halted: eh});
    endtask

    task automatic plain(input logic rdy, input logic ev, input logic [7:0] epc, input logic [31:0] ei, input logic eh);
        add(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 8'd0, 16'd0, rdy, ev, epc, ei, eh);
    endtask

    task automatic redir(input logic [7:0] rpc, input logic [15:0] imm);
        add(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, rpc, imm, 1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
    endtask

    initial begin
        vec_t v;
        m_pc = 0;
        m_halted = 1'b0;

        // Preload memory while held in reset.
        for (int i = 0; i < 64; i++) begin
            v = '{rst: 1'b1, we: 1'b1, wa: 6'(i), wd: pat(i), redir: 1'b0, rpc: 8'd0, imm: 16'd0,
                  ready: 1'b0, e_valid: 1'b0, e_pc: 8'd0, e_instr: 32'd0, e_halted: 1'b0};
            if (i == 0) v.wd = S0;
            if (i == 1) v.wd = 32'd0;
            if (i == 2) v.wd = S2;
            if (i == 3) v.wd = 32'd0;
            step(v, -1);
        end

        // Reset state, straight-line flow
        add(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
        plain(1'b1, 1'b1, 8'd0, S0, 1'b0);
        plain(1'b1, 1'b1, 8'd4, 32'd0, 1'b0);
        plain(1'b1, 1'b1, 8'd8, S2, 1'b0);
        plain(1'b1, 1'b1, 8'd12, 32'd0, 1'b0);
        // Backpressure for 5 cycles, then drain in order
        add(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) plain(1'b0, 1'b1, 8'd0, S0, 1'b0);
        plain(1'b1, 1'b1, 8'd4, 32'd0, 1'b0);
        plain(1'b1, 1'b1, 8'd8, S2, 1'b0);
        plain(1'b1, 1'b1, 8'd12, 32'd0, 1'b0);
        // Redirects: forward, backward, and during a pop
        redir(8'd8, 16'h0003);
        plain(1'b1, 1'b1, 8'd24, pat(6), 1'b0);
        redir(8'd8, 16'hFFFE);
        plain(1'b1, 1'b1, 8'd4, 32'd0, 1'b0);
        plain(1'b1, 1'b1, 8'd8, S2, 1'b0);
        redir(8'd0, 16'h0000);
        plain(1'b1, 1'b1, 8'd4, 32'd0, 1'b0);
        // Halt at imem[2], then resume via redirect to 0
        add(1'b0, 1'b1, 6'd2, HALT, 1'b1, 8'd0, 16'hFFFF, 1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
        plain(1'b1, 1'b1, 8'd0, S0, 1'b0);
        plain(1'b1, 1'b1, 8'd4, 32'd0, 1'b0);
        plain(1'b1, 1'b1, 8'd8, HALT, 1'b1);
        plain(1'b1, 1'b0, 8'd0, 32'd0, 1'b1);
        plain(1'b1, 1'b0, 8'd0, 32'd0, 1'b1);
        redir(8'd0, 16'hFFFF);
        plain(1'b1, 1'b1, 8'd0, S0, 1'b0);
        // Reset with a full buffer; memory survives
        plain(1'b0, 1'b1, 8'd0, S0, 1'b0);
        add(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
        plain(1'b1, 1'b1, 8'd0, S0, 1'b0);
        // Wrap-around
        redir(8'd248, 16'h0000);
        plain(1'b1, 1'b1, 8'd252, pat(63), 1'b0);
        plain(1'b1, 1'b1, 8'd0, S0, 1'b0);
        plain(1'b1, 1'b1, 8'd4, 32'd0, 1'b0);
        // Misaligned redirect_pc
        redir(8'd10, 16'h0000);
        plain(1'b1, 1'b1, 8'd12, 32'd0, 1'b0);

        foreach (tbl[i]) begin
            step(tbl[i], i);
            chk("tbl_valid", i, 32'(out_valid), 32'(tbl[i].e_valid));
            chk("tbl_halted", i, 32'(halted), 32'(tbl[i].e_halted));
            if (tbl[i].e_valid || tbl[i].rst) begin
                chk("tbl_pc", i, 32'(out_pc), 32'(tbl[i].e_pc));
                chk("tbl_instr", i, out_instr, tbl[i].e_instr);
                chk("tbl_opcode", i, 32'(out_opcode), 32'(tbl[i].e_instr[31:26]));
            end
        end

        // Randomised traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            v.rst   = ($urandom_range(0, 199) == 0);
            v.we    = ($urandom_range(0, 7) == 0);
            v.wa    = 6'($urandom);
            v.wd    = ($urandom_range(0, 3) == 0) ? HALT : $urandom;
            v.redir = ($urandom_range(0, 11) == 0);
            v.rpc   = 8'($urandom);
            v.imm   = ($urandom_range(0, 1) == 0) ? 16'($signed($urandom_range(0, 40)) - 20) : 16'($urandom);
            v.ready = ($urandom_range(0, 9) < 7);
            step(v, 1000 + i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
